// File: rtl/hangman_round_ctrl.sv
// hangman_round_ctrl
// Owns one hangman round from start to win/loss and keeps a session
// scoreboard of won and lost rounds.
//
// The word's letter mask is latched on start. Guessed letters arrive as
// one-cycle load pulses. Each accepted guess is resolved in a CHECK cycle
// that decides whether the round is won, lost or continues.
//
// Optional feature macro: HANGMAN_REPEAT_PENALTY_EN
//   When defined, a repeated valid guess also costs a wrong guess and is
//   followed by a CHECK cycle. When undefined, repeats are free.

module hangman_round_ctrl #(
    parameter int ALPHA     = 26,
    parameter int LW        = 5,
    parameter int MAX_WRONG = 6,
    parameter int WW        = 4,
    parameter int SW_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load,
    input  logic [LW-1:0]     load_x,
    input  logic [ALPHA-1:0]  mask,
    output logic [ALPHA-1:0]  guessed_mask,
    output logic [1:0]        game_state,
    output logic [WW-1:0]     wrong_time,
    output logic              repeat_p,
    output logic              invalid_p,
    output logic [SW_W-1:0]   win_count,
    output logic [SW_W-1:0]   loss_count
);

    // One extra bit on the alphabet bound lets ALPHA == 2**LW compare correctly.
    localparam logic [LW:0]      ALPHA_W     = (LW + 1)'(ALPHA);
    localparam logic [WW-1:0]    MAX_WRONG_W = WW'(MAX_WRONG);
    localparam logic [WW-1:0]    WRONG_ONE   = WW'(1'b1);
    localparam logic [ALPHA-1:0] LETTER_ONE  = ALPHA'(1'b1);
    localparam logic [SW_W-1:0]  SCORE_ONE   = SW_W'(1'b1);
    localparam logic [SW_W-1:0]  SCORE_MAX   = {SW_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_CHECK = 3'd2,
        S_WON   = 3'd3,
        S_LOST  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ALPHA-1:0]  word_mask_q, word_mask_d;
    logic [ALPHA-1:0]  guessed_mask_q, guessed_mask_d;
    logic [WW-1:0]     wrong_time_q, wrong_time_d;
    logic [SW_W-1:0]   win_count_q, win_count_d;
    logic [SW_W-1:0]   loss_count_q, loss_count_d;
    logic              repeat_q, repeat_d;
    logic              invalid_q, invalid_d;
    logic [1:0]        game_state_q, game_state_d;

    logic              letter_invalid_s;
    logic [ALPHA-1:0]  letter_onehot_s;
    logic              letter_seen_s;
    logic              letter_in_word_s;
    logic              word_complete_s;

    // Scores stop at all-ones instead of wrapping back to zero.
    function automatic logic [SW_W-1:0] sat_inc(input logic [SW_W-1:0] value);
        logic [SW_W-1:0] result;
        if (value == SCORE_MAX) begin
            result = value;
        end else begin
            result = value + SCORE_ONE;
        end
        return result;
    endfunction

    // External encoding: both PLAY and CHECK look like "playing" outside.
    function automatic logic [1:0] encode_state(input state_t st);
        logic [1:0] code;
        case (st)
            S_IDLE:  code = 2'b00;
            S_PLAY:  code = 2'b01;
            S_CHECK: code = 2'b01;
            S_WON:   code = 2'b10;
            S_LOST:  code = 2'b11;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    // Decode the incoming letter: range check, one-hot form and lookups.
    always_comb begin
        letter_invalid_s = ({1'b0, load_x} >= ALPHA_W);
        letter_onehot_s  = LETTER_ONE << load_x;
        letter_seen_s    = |(guessed_mask_q & letter_onehot_s);
        letter_in_word_s = |(word_mask_q & letter_onehot_s);
        word_complete_s  = ((guessed_mask_q & word_mask_q) == word_mask_q);
    end

    // Next-state and next-output logic for the round FSM.
    always_comb begin
        state_d        = state_q;
        word_mask_d    = word_mask_q;
        guessed_mask_d = guessed_mask_q;
        wrong_time_d   = wrong_time_q;
        win_count_d    = win_count_q;
        loss_count_d   = loss_count_q;
        repeat_d       = 1'b0;
        invalid_d      = 1'b0;

        if (start) begin
            // A new round always takes precedence; a same-cycle load is dropped.
            word_mask_d    = mask;
            guessed_mask_d = {ALPHA{1'b0}};
            wrong_time_d   = {WW{1'b0}};
            state_d        = S_CHECK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_PLAY: begin
                    if (!load) begin
                        state_d = S_PLAY;
                    end else if (letter_invalid_s) begin
                        invalid_d = 1'b1;
                    end else if (letter_seen_s) begin
                        repeat_d = 1'b1;
`ifdef HANGMAN_REPEAT_PENALTY_EN
                        // PLAY implies wrong_time < MAX_WRONG, so this cannot overshoot.
                        wrong_time_d = wrong_time_q + WRONG_ONE;
                        state_d      = S_CHECK;
`else
                        state_d = S_PLAY;
`endif
                    end else begin
                        guessed_mask_d = guessed_mask_q | letter_onehot_s;
                        if (letter_in_word_s) begin
                            wrong_time_d = wrong_time_q;
                        end else begin
                            wrong_time_d = wrong_time_q + WRONG_ONE;
                        end
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    // A completed word wins even if the wrong limit was also reached.
                    if (word_complete_s) begin
                        state_d     = S_WON;
                        win_count_d = sat_inc(win_count_q);
                    end else if (wrong_time_q >= MAX_WRONG_W) begin
                        state_d      = S_LOST;
                        loss_count_d = sat_inc(loss_count_q);
                    end else begin
                        state_d = S_PLAY;
                    end
                end
                S_WON: begin
                    state_d = S_WON;
                end
                S_LOST: begin
                    state_d = S_LOST;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        game_state_d = encode_state(state_d);
    end

    // Round state, scoreboard and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            word_mask_q    <= {ALPHA{1'b0}};
            guessed_mask_q <= {ALPHA{1'b0}};
            wrong_time_q   <= {WW{1'b0}};
            win_count_q    <= {SW_W{1'b0}};
            loss_count_q   <= {SW_W{1'b0}};
            repeat_q       <= 1'b0;
            invalid_q      <= 1'b0;
            game_state_q   <= 2'b00;
        end else begin
            state_q        <= state_d;
            word_mask_q    <= word_mask_d;
            guessed_mask_q <= guessed_mask_d;
            wrong_time_q   <= wrong_time_d;
            win_count_q    <= win_count_d;
            loss_count_q   <= loss_count_d;
            repeat_q       <= repeat_d;
            invalid_q      <= invalid_d;
            game_state_q   <= game_state_d;
        end
    end

    assign guessed_mask = guessed_mask_q;
    assign game_state   = game_state_q;
    assign wrong_time   = wrong_time_q;
    assign repeat_p     = repeat_q;
    assign invalid_p    = invalid_q;
    assign win_count    = win_count_q;
    assign loss_count   = loss_count_q;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Directed testbench for hangman_round_ctrl with default parameters.
// Inputs change 1 time unit after a rising edge and outputs are sampled there.

module tb_hangman_round_ctrl;

    localparam int ALPHA = 26;
    localparam int LW    = 5;
    localparam int WW    = 4;
    localparam int SW_W  = 8;
`ifdef HANGMAN_REPEAT_PENALTY_EN
    localparam int REP_PEN = 1;
`else
    localparam int REP_PEN = 0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic              load;
    logic [LW-1:0]     load_x;
    logic [ALPHA-1:0]  mask;
    logic [ALPHA-1:0]  guessed_mask;
    logic [1:0]        game_state;
    logic [WW-1:0]     wrong_time;
    logic              repeat_p;
    logic              invalid_p;
    logic [SW_W-1:0]   win_count;
    logic [SW_W-1:0]   loss_count;

    int compared;
    int mismatched;

    hangman_round_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load         (load),
        .load_x       (load_x),
        .mask         (mask),
        .guessed_mask (guessed_mask),
        .game_state   (game_state),
        .wrong_time   (wrong_time),
        .repeat_p     (repeat_p),
        .invalid_p    (invalid_p),
        .win_count    (win_count),
        .loss_count   (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ALPHA-1:0] m);
        start = 1'b1;
        mask  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_load(input int x);
        load   = 1'b1;
        load_x = LW'(x);
        tick();
        load   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        compared++;
        if ({guessed_mask, game_state, wrong_time, repeat_p, invalid_p, win_count, loss_count} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got gm=%h gs=%b wt=%0d rp=%b ip=%b win=%0d loss=%0d, want all 0",
                     guessed_mask, game_state, wrong_time, repeat_p, invalid_p, win_count, loss_count);
        end
        reset = 1'b1;
        tick();
        compared++;
        if (game_state !== 2'b00) begin
            mismatched++;
            $display("FAIL idle_after_reset: game_state got %b want 00", game_state);
        end
    endtask

    task automatic test_win();
        pulse_start(26'h0000005);
        compared++;
        if (game_state !== 2'b01 || guessed_mask !== 26'h0) begin
            mismatched++;
            $display("FAIL win_start: gs=%b gm=%h want 01/0", game_state, guessed_mask);
        end
        tick();
        pulse_load(0);
        tick();
        pulse_load(2);
        compared++;
        if (guessed_mask !== 26'h0000005 || game_state !== 2'b01) begin
            mismatched++;
            $display("FAIL win_guesses: gm=%h gs=%b want 0000005/01", guessed_mask, game_state);
        end
        tick();
        compared++;
        if (game_state !== 2'b10 || win_count !== 8'd1 || wrong_time !== 4'd0 || loss_count !== 8'd0) begin
            mismatched++;
            $display("FAIL win_result: gs=%b win=%0d wt=%0d loss=%0d want 10/1/0/0",
                     game_state, win_count, wrong_time, loss_count);
        end
    endtask

    task automatic test_loss();
        pulse_start(26'h0000001);
        tick();
        for (int i = 1; i <= 6; i++) begin
            pulse_load(i);
            compared++;
            if (wrong_time !== WW'(i)) begin
                mismatched++;
                $display("FAIL loss_wrong_step%0d: wrong_time got %0d want %0d", i, wrong_time, i);
            end
            tick();
            compared++;
            if (game_state !== ((i < 6) ? 2'b01 : 2'b11)) begin
                mismatched++;
                $display("FAIL loss_state_step%0d: game_state got %b want %b",
                         i, game_state, (i < 6) ? 2'b01 : 2'b11);
            end
        end
        compared++;
        if (loss_count !== 8'd1 || win_count !== 8'd1) begin
            mismatched++;
            $display("FAIL loss_count: loss=%0d win=%0d want 1/1", loss_count, win_count);
        end
        pulse_load(7);
        tick();
        compared++;
        if (wrong_time !== 4'd6 || guessed_mask !== 26'h000007E || game_state !== 2'b11 ||
            repeat_p !== 1'b0 || invalid_p !== 1'b0) begin
            mismatched++;
            $display("FAIL loss_hold: wt=%0d gm=%h gs=%b rp=%b ip=%b want 6/000007e/11/0/0",
                     wrong_time, guessed_mask, game_state, repeat_p, invalid_p);
        end
    endtask

    task automatic test_repeat_invalid();
        pulse_start(26'h0000010);
        tick();
        pulse_load(3);
        tick();
        pulse_load(3);
        compared++;
        if (repeat_p !== 1'b1 || wrong_time !== WW'(1 + REP_PEN) || guessed_mask !== 26'h0000008) begin
            mismatched++;
            $display("FAIL repeat_pulse: rp=%b wt=%0d gm=%h want 1/%0d/0000008",
                     repeat_p, wrong_time, guessed_mask, 1 + REP_PEN);
        end
        tick();
        compared++;
        if (repeat_p !== 1'b0 || game_state !== 2'b01) begin
            mismatched++;
            $display("FAIL repeat_one_cycle: rp=%b gs=%b want 0/01", repeat_p, game_state);
        end
        pulse_load(27);
        compared++;
        if (invalid_p !== 1'b1 || repeat_p !== 1'b0 || guessed_mask !== 26'h0000008 ||
            wrong_time !== WW'(1 + REP_PEN) || game_state !== 2'b01) begin
            mismatched++;
            $display("FAIL invalid_pulse: ip=%b rp=%b gm=%h wt=%0d gs=%b want 1/0/0000008/%0d/01",
                     invalid_p, repeat_p, guessed_mask, wrong_time, game_state, 1 + REP_PEN);
        end
        tick();
        compared++;
        if (invalid_p !== 1'b0 || game_state !== 2'b01) begin
            mismatched++;
            $display("FAIL invalid_one_cycle: ip=%b gs=%b want 0/01", invalid_p, game_state);
        end
    endtask

    task automatic test_empty_word();
        pulse_start(26'h0);
        compared++;
        if (game_state !== 2'b01) begin
            mismatched++;
            $display("FAIL empty_check: game_state got %b want 01", game_state);
        end
        tick();
        compared++;
        if (game_state !== 2'b10 || win_count !== 8'd2 || loss_count !== 8'd1) begin
            mismatched++;
            $display("FAIL empty_win: gs=%b win=%0d loss=%0d want 10/2/1", game_state, win_count, loss_count);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start(26'h0000003);
        tick();
        pulse_load(0);
        tick();
        start  = 1'b1;
        mask   = 26'h0000003;
        load   = 1'b1;
        load_x = 5'd1;
        tick();
        start  = 1'b0;
        load   = 1'b0;
        compared++;
        if (guessed_mask !== 26'h0 || wrong_time !== 4'd0 || repeat_p !== 1'b0 || invalid_p !== 1'b0 ||
            game_state !== 2'b01 || win_count !== 8'd2 || loss_count !== 8'd1) begin
            mismatched++;
            $display("FAIL restart_drop_load: gm=%h wt=%0d rp=%b ip=%b gs=%b win=%0d loss=%0d want 0/0/0/0/01/2/1",
                     guessed_mask, wrong_time, repeat_p, invalid_p, game_state, win_count, loss_count);
        end
        tick();
        compared++;
        if (game_state !== 2'b01 || guessed_mask !== 26'h0) begin
            mismatched++;
            $display("FAIL restart_play: gs=%b gm=%h want 01/0", game_state, guessed_mask);
        end
        #3;
        reset = 1'b0;
        #1;
        compared++;
        if ({guessed_mask, game_state, wrong_time, repeat_p, invalid_p, win_count, loss_count} !== '0) begin
            mismatched++;
            $display("FAIL async_reset: gm=%h gs=%b wt=%0d win=%0d loss=%0d want all 0",
                     guessed_mask, game_state, wrong_time, win_count, loss_count);
        end
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 255; i++) begin
            pulse_start(26'h0);
            tick();
        end
        compared++;
        if (win_count !== 8'd255 || loss_count !== 8'd0) begin
            mismatched++;
            $display("FAIL win_to_255: win=%0d loss=%0d want 255/0", win_count, loss_count);
        end
        pulse_start(26'h0);
        tick();
        compared++;
        if (win_count !== 8'd255 || game_state !== 2'b10) begin
            mismatched++;
            $display("FAIL win_saturate: win=%0d gs=%b want 255/10", win_count, game_state);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        start      = 1'b0;
        load       = 1'b0;
        load_x     = '0;
        mask       = '0;
        test_reset();
        test_win();
        test_loss();
        test_repeat_invalid();
        test_empty_word();
        test_back_to_back();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hangman_round_ctrl.md
Name: hangman_round_ctrl

Overview:
- Parametrised successor to the game handler: owns one hangman round from start to win/loss and keeps a session scoreboard.
- Latches the word's letter mask at round start, accepts guessed letters from the keyboard handler, and tracks guessed letters and wrong count.
- Detects repeated and out-of-range guesses, and counts wins/losses across rounds.
- Sits between keyboard_handler/word_ram and vga_handler/hex displays.

Parameters:
- ALPHA, 26, alphabet size; letter codes 0..ALPHA-1 are valid.
- LW, 5, letter code width; must satisfy 2^LW >= ALPHA.
- MAX_WRONG, 6, wrong guesses that end the round as lost; range 1..2^WW-1.
- WW, 4, width of wrong_time.
- SW_W, 8, width of each score counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; latch mask and begin a new round.
- load  input  1  one-cycle pulse; letter on load_x is valid.
- load_x  input  LW  guessed letter code.
- mask  input  ALPHA  letters present in the current word; sampled only on start.
- guessed_mask  output  ALPHA  letters guessed so far (correct and wrong).
- game_state  output  2  00 idle, 01 playing, 10 won, 11 lost.
- wrong_time  output  WW  wrong guesses this round.
- repeat_p  output  1  one-cycle pulse: guessed letter already in guessed_mask.
- invalid_p  output  1  one-cycle pulse: load_x >= ALPHA.
- win_count  output  SW_W  rounds won since reset; saturates at all-ones.
- loss_count  output  SW_W  rounds lost since reset; saturates at all-ones.

Behaviour:
- Reset (async, reset=0):
  - state IDLE; guessed_mask, wrong_time, word_mask and both counters = 0.
  - repeat_p = invalid_p = 0; game_state = 00.
- FSM states: IDLE, PLAY, CHECK, WON, LOST. game_state = 00 for IDLE, 01 for PLAY and CHECK, 10 for WON, 11 for LOST.
- start (accepted in any state), at the next edge:
  - word_mask <= mask; guessed_mask <= 0; wrong_time <= 0; state <= CHECK.
  - A start during PLAY/CHECK abandons the round; no score change.
- start and load in the same cycle: start wins, load is dropped with no pulses.
- load in PLAY, resolved at the next edge:
  - load_x >= ALPHA: invalid_p=1; no other change; stay PLAY.
  - guessed_mask[load_x]=1: repeat_p=1; no other change; stay PLAY.
  - Otherwise: set guessed_mask[load_x]; if word_mask[load_x]=0 then wrong_time += 1; state <= CHECK.
- load in IDLE, CHECK, WON or LOST: ignored, no pulses. Guess-to-guess throughput is therefore 2 cycles; keyboard pulses are far sparser than that.
- CHECK, evaluated with a 1-cycle result:
  - (guessed_mask & word_mask) == word_mask -> WON; win_count += 1 (saturating).
  - else wrong_time >= MAX_WRONG -> LOST; loss_count += 1 (saturating).
  - else -> PLAY.
  - Win takes priority if both conditions hold.
  - An empty word_mask (0) wins immediately on the first CHECK.
- WON/LOST: hold all outputs until start or reset.
- wrong_time never exceeds MAX_WRONG.
- repeat_p and invalid_p are registered, high exactly one cycle.
- Reset mid-round: immediate return to reset values; scores are lost.

Optional Feature:
- Macro: HANGMAN_REPEAT_PENALTY_EN.
- Defined: a repeated valid guess in PLAY also increments wrong_time and goes to CHECK, so it can cause a loss. repeat_p still pulses; guessed_mask is unchanged.
- Undefined: repeats are free, as described in Behaviour.

Test Plan:
- Reset, then start with mask=0x0000005 (A,C); load 0, then load 2 -> guessed_mask=0x5, game_state=10, win_count=1, wrong_time=0.
- start with mask=0x0000001; load codes 1..6 -> wrong_time steps to 6, game_state=11 after the 6th CHECK, loss_count=1; a further load changes nothing.
- In PLAY, load 3 twice -> second load gives repeat_p one cycle, wrong_time unchanged; load_x=27 -> invalid_p one cycle, no state change. With HANGMAN_REPEAT_PENALTY_EN defined, the repeat gives wrong_time +1.
- start with mask=0 -> game_state=10 two edges later, win_count +1.
- Mid-round start asserted with a simultaneous load -> load dropped, guessed_mask=0, wrong_time=0, scores unchanged. Then assert reset low asynchronously -> all outputs 0 before the next edge.
- Force win_count=255 (SW_W=8) via 255 quick empty-mask rounds, then one more win -> win_count stays 255.
